zoom_sequencer: RTL

- Frame-level controller that runs one zoom pass over the 160x120 source frame after a zoom request.
- Walks output coordinates for the selected algorithm and issues source-memory reads, one outstanding at a time.
- Computes each output pixel (replicate, decimate or 2x2 average) and writes it to the output framebuffer through a ready/enable handshake.
- Sits between the algorithm/zoom selection logic and the two frame memories.

---
 rtl/zoom_sequencer_if.sv | 42 ++++
 rtl/zoom_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/zoom_sequencer_if.sv
// ---------------------------------------------------------------------------
// zoom_sequencer_if
//   Memory-side bus of the zoom sequencer: a single-outstanding read port
//   towards the source frame and a ready/enable write port towards the
//   output framebuffer.
//
//   Read side : RD_EN, RD_ADDR (sequencer -> memory)
//               RD_DATA, RD_VALID (memory -> sequencer)
//   Write side: WR_EN, WR_ADDR, WR_DATA (sequencer -> framebuffer)
//               WR_READY (framebuffer -> sequencer)
//
//   master : the sequencer
//   slave  : the memory / framebuffer side
// ---------------------------------------------------------------------------
interface zoom_sequencer_if #(
    parameter int PIX_W = 8,
    parameter int RA_W  = 15,
    parameter int WA_W  = 17
) ();
    logic             RD_EN;
    logic [RA_W-1:0]  RD_ADDR;
    logic [PIX_W-1:0] RD_DATA;
    logic             RD_VALID;
    logic             WR_EN;
    logic [WA_W-1:0]  WR_ADDR;
    logic [PIX_W-1:0] WR_DATA;
    logic             WR_READY;

    modport master (
        output RD_EN, RD_ADDR,
        input  RD_DATA, RD_VALID,
        output WR_EN, WR_ADDR, WR_DATA,
        input  WR_READY
    );

    modport slave (
        input  RD_EN, RD_ADDR,
        output RD_DATA, RD_VALID,
        input  WR_EN, WR_ADDR, WR_DATA,
        output WR_READY
    );
endinterface

// File: rtl/zoom_sequencer.sv
// ---------------------------------------------------------------------------
// zoom_sequencer
//   Runs one zoom pass over the SRC_W x SRC_H source frame per accepted
//   START. Output pixels are produced in row-major order; each needs one
//   source read (NN/PR/DC) or four (BA, 2x2 average), with one read
//   outstanding at a time, followed by one handshaked framebuffer write.
//
//   Ports
//     CLK, RESET_N       clock (rising edge) / async active-low reset
//     START              zoom request, honoured only in IDLE
//     ALGORITHM          0=NN, 1=PR (2x up), 2=DC (2x down), 3=BA (2x2 avg)
//     BUSY, DONE         run in progress / one-cycle end-of-run pulse
//     OUT_WIDTH/HEIGHT   output dimensions of the current or last run
//     bus (master)       source read port and framebuffer write port
//
//   Build option
//     ZOOM_BA_ROUND_EN   defined: BA output is (sum+2)>>2 (round half up)
//                        undefined: BA output is sum>>2 (truncate)
// ---------------------------------------------------------------------------
module zoom_sequencer #(
    parameter int SRC_W = 160,
    parameter int SRC_H = 120,
    parameter int PIX_W = 8,
    parameter int RA_W  = 15,
    parameter int WA_W  = 17
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             START,
    input  logic [1:0]       ALGORITHM,
    output logic             BUSY,
    output logic             DONE,
    output logic [9:0]       OUT_WIDTH,
    output logic [8:0]       OUT_HEIGHT,
    zoom_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_WRITE,
        ST_FIN
    } state_e;

    typedef enum logic [1:0] {
        ALG_NN = 2'd0,
        ALG_PR = 2'd1,
        ALG_DC = 2'd2,
        ALG_BA = 2'd3
    } alg_e;

    // Four PIX_W samples summed need two extra bits.
    localparam int ACC_W = PIX_W + 2;

    state_e           state_q;
    alg_e             alg_q;
    logic [9:0]       ox_q;
    logic [8:0]       oy_q;
    logic [1:0]       sub_q;
    logic [ACC_W-1:0] acc_q;
    logic             busy_q;
    logic             done_q;
    logic             rd_en_q;
    logic [RA_W-1:0]  rd_addr_q;
    logic             wr_en_q;
    logic [WA_W-1:0]  wr_addr_q;
    logic [PIX_W-1:0] wr_data_q;
    logic [9:0]       out_w_q;
    logic [8:0]       out_h_q;

    logic [ACC_W-1:0] sum_d;
    logic [PIX_W-1:0] avg_d;
    logic             last_col_d;
    logic             last_pix_d;
    logic [9:0]       ox_d;
    logic [8:0]       oy_d;

    // Source address of read number `sub` for output pixel (ox, oy).
    function automatic logic [RA_W-1:0] src_addr(
        input alg_e       alg,
        input logic [9:0] ox,
        input logic [8:0] oy,
        input logic [1:0] sub
    );
        logic [31:0] sx;
        logic [31:0] sy;
        case (alg)
            ALG_NN, ALG_PR: begin
                sx = {23'd0, ox[9:1]};
                sy = {24'd0, oy[8:1]};
            end
            ALG_DC: begin
                sx = {21'd0, ox, 1'b0};
                sy = {22'd0, oy, 1'b0};
            end
            default: begin
                // sub[0] picks the right column, sub[1] the lower row.
                sx = {21'd0, ox, sub[0]};
                sy = {22'd0, oy, sub[1]};
            end
        endcase
        return RA_W'(sy * 32'(SRC_W) + sx);
    endfunction

    always_comb begin
        // NOTE: every signal driven here is assigned on every path, so no
        // latch is inferred.
        sum_d = acc_q + ACC_W'(bus.RD_DATA);
`ifdef ZOOM_BA_ROUND_EN
        avg_d = PIX_W'((sum_d + ACC_W'(2)) >> 2);
`else
        avg_d = PIX_W'(sum_d >> 2);
`endif
        last_col_d = (ox_q == out_w_q - 10'd1);
        last_pix_d = last_col_d && (oy_q == out_h_q - 9'd1);
        ox_d       = last_col_d ? 10'd0 : ox_q + 10'd1;
        oy_d       = last_col_d ? oy_q + 9'd1 : oy_q;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= ST_IDLE;
            alg_q     <= ALG_NN;
            ox_q      <= '0;
            oy_q      <= '0;
            sub_q     <= '0;
            acc_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            out_w_q   <= 10'(SRC_W);
            out_h_q   <= 9'(SRC_H);
        end else begin
            // NOTE: non-blocking assignments, so every register here sees
            // the pre-edge value of every other register.
            case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        alg_q     <= alg_e'(ALGORITHM);
                        ox_q      <= '0;
                        oy_q      <= '0;
                        sub_q     <= '0;
                        acc_q     <= '0;
                        wr_addr_q <= '0;
                        out_w_q   <= ALGORITHM[1] ? 10'(SRC_W / 2) : 10'(2 * SRC_W);
                        out_h_q   <= ALGORITHM[1] ? 9'(SRC_H / 2) : 9'(2 * SRC_H);
                        // Pixel (0,0) reads source address 0 for every algorithm.
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    rd_en_q <= 1'b0;
                    state_q <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (bus.RD_VALID) begin
                        if (alg_q == ALG_BA) begin
                            if (sub_q != 2'd3) begin
                                acc_q     <= sum_d;
                                sub_q     <= sub_q + 2'd1;
                                rd_en_q   <= 1'b1;
                                rd_addr_q <= src_addr(alg_q, ox_q, oy_q, sub_q + 2'd1);
                                state_q   <= ST_ISSUE;
                            end else begin
                                wr_data_q <= avg_d;
                                acc_q     <= '0;
                                sub_q     <= '0;
                                wr_en_q   <= 1'b1;
                                state_q   <= ST_WRITE;
                            end
                        end else begin
                            wr_data_q <= bus.RD_DATA;
                            wr_en_q   <= 1'b1;
                            state_q   <= ST_WRITE;
                        end
                    end
                end

                ST_WRITE: begin
                    // Address and data stay put until the framebuffer takes them.
                    if (bus.WR_READY) begin
                        wr_en_q <= 1'b0;
                        if (last_pix_d) begin
                            done_q  <= 1'b1;
                            state_q <= ST_FIN;
                        end else begin
                            ox_q      <= ox_d;
                            oy_q      <= oy_d;
                            wr_addr_q <= wr_addr_q + WA_W'(1);
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= src_addr(alg_q, ox_d, oy_d, 2'd0);
                            state_q   <= ST_ISSUE;
                        end
                    end
                end

                ST_FIN: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign BUSY        = busy_q;
    assign DONE        = done_q;
    assign OUT_WIDTH   = out_w_q;
    assign OUT_HEIGHT  = out_h_q;
    assign bus.RD_EN   = rd_en_q;
    assign bus.RD_ADDR = rd_addr_q;
    assign bus.WR_EN   = wr_en_q;
    assign bus.WR_ADDR = wr_addr_q;
    assign bus.WR_DATA = wr_data_q;

endmodule
